// File: rtl/ddr_wr_pkg.sv
// ddr_wr_pkg: shared types and helpers for the DDR3 write-data serializer.
// Holds the burst FSM state enum, burst word counts and words_for().
package ddr_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    POST
  } wr_state_e;

  localparam int BL8_WORDS = 4;
  localparam int BC4_WORDS = 2;

  // Words (two beats each) consumed by one burst.
  function automatic logic [2:0] words_for(input logic bc4);
    return bc4 ? 3'(BC4_WORDS) : 3'(BL8_WORDS);
  endfunction

endpackage

// File: rtl/wr_data_fifo.sv
// wr_data_fifo: synchronous show-ahead FIFO (dout = head word).
// Ports: clock, reset, push, pop, din, dout, full, empty, count.
module wr_data_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // No bypass: a full FIFO refuses the push even if it pops.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/ddr_wr_burst_ser.sv
// ddr_wr_burst_ser: DDR3 write-data serializer (FIFO -> DQ/DQS/DM beats).
// In: in_data/in_mask/in_valid, wr_start/bc4. Out: in_ready, start_ready, dq/dm/dqs(+oe), busy. DM via DDR_WR_DM_EN.
module ddr_wr_burst_ser
  import ddr_wr_pkg::*;
#(
  parameter int BW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2*BW-1:0]     in_data,
  input  logic [2*BW/8-1:0]   in_mask,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                wr_start,
  input  logic                bc4,
  output logic                start_ready,
  output logic [BW-1:0]       dq,
  output logic                dq_oe,
  output logic [BW/8-1:0]     dm,
  output logic                dqs,
  output logic                dqs_oe,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef DDR_WR_DM_EN
  localparam int MH = BW / 8;
  localparam int FW = 2*BW + 2*MH;
`else
  localparam int FW = 2*BW;
`endif

  logic [FW-1:0] fdin;
  logic [FW-1:0] fdout;
  logic          full;
  logic          empty_unused;
  logic [CW-1:0] count;
  logic [CW-1:0] avail;

  wr_state_e     state_q;
  logic [1:0]    wcnt_q;
  logic          bc4_q;
  logic          dq_oe_q;
  logic          dqs_oe_q;
  logic          dqs_en_q;
  logic [1:0]    n_last;
  logic          last;
  logic          slot_ok;
  logic          pop_base;
  logic          accept;
  logic          pop;

  logic [BW-1:0] lo_q;
  logic [BW-1:0] hi_q;
  logic [BW-1:0] hi_n;

`ifdef DDR_WR_DM_EN
  assign fdin = {in_mask, in_data};
`else
  assign fdin = in_data;
  logic unused_mask;
  assign unused_mask = ^in_mask;
`endif

  wr_data_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .din   (fdin),
    .dout  (fdout),
    .full  (full),
    .empty (empty_unused),
    .count (count)
  );

  assign in_ready = ~full;

  assign n_last   = 2'(words_for(bc4_q) - 3'd1);
  assign last     = (state_q == DATA) && (wcnt_q == n_last);
  assign slot_ok  = (state_q == IDLE) || (state_q == POST) || last;
  // Pops owed to the current burst; the seamless pop is added below.
  assign pop_base = (state_q == PRE) || ((state_q == DATA) && !last);
  assign avail    = count - CW'(pop_base);

  assign start_ready = slot_ok && (avail >= CW'(words_for(bc4)));
  assign accept      = wr_start & start_ready;
  assign pop         = pop_base | (last & accept);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      bc4_q    <= 1'b0;
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
      dqs_en_q <= 1'b0;
    end else begin
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
      dqs_en_q <= 1'b0;
      case (state_q)
        IDLE, POST: begin
          if (accept) begin
            state_q  <= PRE;
            bc4_q    <= bc4;
            dqs_oe_q <= 1'b1;
          end else begin
            state_q  <= IDLE;
          end
        end
        PRE: begin
          state_q  <= DATA;
          wcnt_q   <= '0;
          dq_oe_q  <= 1'b1;
          dqs_oe_q <= 1'b1;
          dqs_en_q <= 1'b1;
        end
        DATA: begin
          if (!last || accept) begin
            wcnt_q   <= last ? 2'd0 : wcnt_q + 2'd1;
            if (last) bc4_q <= bc4;
            dq_oe_q  <= 1'b1;
            dqs_oe_q <= 1'b1;
            dqs_en_q <= 1'b1;
          end else begin
            state_q  <= POST;
            dqs_oe_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (pop) begin
      lo_q <= fdout[BW-1:0];
      hi_q <= fdout[2*BW-1:BW];
    end
  end

  // Second beat is retimed to the falling edge for the low clock phase.
  always_ff @(negedge clock) begin
    if (reset) hi_n <= '0;
    else       hi_n <= hi_q;
  end

  assign dq = clock ? lo_q : hi_n;

`ifdef DDR_WR_DM_EN
  logic [MH-1:0] mlo_q;
  logic [MH-1:0] mhi_q;
  logic [MH-1:0] mhi_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      mlo_q <= '0;
      mhi_q <= '0;
    end else if (pop) begin
      mlo_q <= fdout[2*BW +: MH];
      mhi_q <= fdout[2*BW+MH +: MH];
    end
  end

  always_ff @(negedge clock) begin
    if (reset) mhi_n <= '0;
    else       mhi_n <= mhi_q;
  end

  assign dm = clock ? mlo_q : mhi_n;
`else
  assign dm = '0;
`endif

  assign dq_oe  = dq_oe_q;
  assign dqs_oe = dqs_oe_q;
  assign dqs    = dqs_en_q & clock;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_wr_burst_ser.sv
// tb_ddr_wr_burst_ser: directed table-driven bench for ddr_wr_burst_ser.
// BL8, refused/accepted BC4, seamless BL8+BL8 with full FIFO, mid-burst reset.
module tb_ddr_wr_burst_ser;

`ifdef DDR_WR_DM_EN
  localparam bit DM_ON = 1'b1;
`else
  localparam bit DM_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mask = '0;
  logic        in_valid = 1'b0;
  logic        wr_start = 1'b0;
  logic        bc4 = 1'b0;
  logic        in_ready;
  logic        start_ready;
  logic [7:0]  dq;
  logic        dq_oe;
  logic [0:0]  dm;
  logic        dqs;
  logic        dqs_oe;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          v;
    logic [15:0] d;
    logic [1:0]  m;
    bit          s;
    bit          b;
    bit          e_rdy;
    bit          e_sr;
    bit          e_busy;
    bit          e_oe;
    bit          e_soe;
    bit          e_dqs;
    logic [7:0]  e_dqh;
    logic [7:0]  e_dql;
    bit          e_dml;
  } vec_t;

  vec_t tbl[$];

  ddr_wr_burst_ser #(.BW(8), .DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_mask     (in_mask),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wr_start    (wr_start),
    .bc4         (bc4),
    .start_ready (start_ready),
    .dq          (dq),
    .dq_oe       (dq_oe),
    .dm          (dm),
    .dqs         (dqs),
    .dqs_oe      (dqs_oe),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit v, input logic [15:0] d,
                     input logic [1:0] m, input bit s, input bit b,
                     input bit rdy, input bit sr, input bit bsy,
                     input bit oe, input bit soe, input bit qs,
                     input logic [7:0] dqh, input logic [7:0] dql,
                     input bit dml);
    vec_t r;
    r.v = v; r.d = d; r.m = m; r.s = s; r.b = b;
    r.e_rdy = rdy; r.e_sr = sr; r.e_busy = bsy;
    r.e_oe = oe; r.e_soe = soe; r.e_dqs = qs;
    r.e_dqh = dqh; r.e_dql = dql; r.e_dml = dml;
    tbl.push_back(r);
  endtask

  task automatic drive(input bit v, input logic [15:0] d,
                       input logic [1:0] m, input bit s, input bit b);
    in_valid = v;
    in_data  = d;
    in_mask  = m;
    wr_start = s;
    bc4      = b;
  endtask

  initial begin
    // BL8: 4 pushes, start, PRE, 4 DATA, POST, IDLE
    add(1, 16'h1100, 2'b10, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(1, 16'h3322, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(1, 16'h5544, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(1, 16'h7766, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 1, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 1, 1, 1, 8'h00, 8'h11, 1);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 1, 1, 1, 8'h22, 8'h33, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 1, 1, 1, 8'h44, 8'h55, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 1, 1, 1, 8'h66, 8'h77, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    // 2 words: BL8 refused, BC4 accepted
    add(1, 16'hBBAA, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(1, 16'hDDCC, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 1, 1, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 1, 1, 1, 8'hAA, 8'hBB, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 1, 1, 1, 8'hCC, 8'hDD, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    // fill to DEPTH, extra word refused, seamless BL8 + BL8
    for (int k = 0; k < 8; k++)
      add(1, {8'(129 + 2*k), 8'(128 + 2*k)}, 2'b00, 0, 0,
          1, k >= 4, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(1, 16'hEEEE, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(1, 16'hEEEE, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0);
    for (int k = 0; k < 8; k++)
      add(0, 16'h0000, 2'b00, k == 3, 0, 1, k == 3, 1, 1, 1, 1,
          8'(128 + 2*k), 8'(129 + 2*k), 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0);
    add(0, 16'h0000, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

    // reset state
    repeat (2) @(posedge clock);
    #3;
    check("rst in_ready", in_ready, 1);
    check("rst start_ready", start_ready, 0);
    check("rst busy", busy, 0);
    check("rst dq", dq, 0);
    check("rst dm", dm, 0);
    check("rst dq_oe", dq_oe, 0);
    check("rst dqs", dqs, 0);
    check("rst dqs_oe", dqs_oe, 0);
    @(negedge clock);
    #2;
    check("rst dq low", dq, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clock);
      #1 drive(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].s, tbl[i].b);
      #2;
      check($sformatf("c%0d in_ready", i), in_ready, tbl[i].e_rdy);
      check($sformatf("c%0d start_ready", i), start_ready, tbl[i].e_sr);
      check($sformatf("c%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("c%0d dq_oe", i), dq_oe, tbl[i].e_oe);
      check($sformatf("c%0d dqs_oe", i), dqs_oe, tbl[i].e_soe);
      check($sformatf("c%0d dqs hi", i), dqs, tbl[i].e_dqs);
      if (tbl[i].e_oe) begin
        check($sformatf("c%0d dq beat0", i), dq, tbl[i].e_dqh);
        check($sformatf("c%0d dm beat0", i), dm, 0);
      end
      @(negedge clock);
      #2;
      check($sformatf("c%0d dqs lo", i), dqs, 0);
      check($sformatf("c%0d dq_oe lo", i), dq_oe, tbl[i].e_oe);
      if (tbl[i].e_oe) begin
        check($sformatf("c%0d dq beat1", i), dq, tbl[i].e_dql);
        check($sformatf("c%0d dm beat1", i), dm, tbl[i].e_dml & DM_ON);
      end
    end

    // reset in the second DATA cycle of a BL8
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1 drive(1, 16'h4140 + 16'(k * 16'h0202), 2'b00, 0, 0);
    end
    @(posedge clock);
    #1 drive(0, 16'h0000, 2'b00, 1, 0);
    @(posedge clock);
    #1 drive(0, 16'h0000, 2'b00, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    bc4 = 1'b1;
    #2;
    check("mid busy", busy, 1);
    check("mid dq", dq, 8'h42);
    @(posedge clock);
    #3;
    check("mrst busy", busy, 0);
    check("mrst in_ready", in_ready, 1);
    check("mrst start_ready", start_ready, 0);
    check("mrst dq", dq, 0);
    check("mrst dm", dm, 0);
    check("mrst dq_oe", dq_oe, 0);
    check("mrst dqs", dqs, 0);
    check("mrst dqs_oe", dqs_oe, 0);
    @(negedge clock);
    #2;
    check("mrst dq low", dq, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #3;
    check("post-rst start_ready", start_ready, 0);
    check("post-rst busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_wr_burst_ser.md
# ddr_wr_burst_ser

Parametrised DDR3 write-data serializer in the memory controller write path, between the controller's write-data interface and the DRAM DQ/DQS/DM pins. It buffers controller write words in an internal FIFO, then drives each accepted burst as double-data-rate beats. Burst length is selectable per burst (BL8 or BC4). Bursts carry a DQS preamble and postamble, and back-to-back bursts run seamlessly.

## Interface
- `BW`, default 8: DQ width in bits per beat; multiple of 8.
- `DEPTH`, default 8: FIFO depth in 2*BW-bit words; power of two, at least 4.
- `clock` in 1: memory clock; DDR output mux select.
- `reset` in 1: synchronous, active-high. The clock is `clock`.
- `in_data` in 2*BW: one word = two beats; low half goes first.
- `in_mask` in 2*BW/8: byte masks matching `in_data`, 1 = masked.
- `in_valid` in 1: `in_data`/`in_mask` are valid.
- `in_ready` out 1: FIFO can accept a word (not full).
- `wr_start` in 1: start-burst request, sampled at posedge.
- `bc4` in 1: sampled with `wr_start`; 1 = BC4 (2 words), 0 = BL8 (4 words).
- `start_ready` out 1: `wr_start` will be accepted this cycle.
- `dq` out BW: DDR data beat.
- `dq_oe` out 1: DQ output enable.
- `dm` out BW/8: DDR data mask beat.
- `dqs` out 1: data strobe.
- `dqs_oe` out 1: DQS output enable.
- `busy` out 1: state is not IDLE.

## Operation
- Input side:
  - A word is pushed when `in_valid & in_ready`.
  - `in_ready = ~full`. A word offered while the FIFO is full is not taken; there is no push-on-pop bypass when full.
- FSM states: IDLE, PRE, DATA, POST.
- Beat counter `wcnt` counts words in the current burst; N = 2 (BC4) or 4 (BL8).
- `start_ready` is high when both hold:
  - state is IDLE or POST, or state is DATA and `wcnt == N-1`;
  - FIFO count, minus the pop happening this cycle, is at least N for the requested `bc4`.
- A burst is accepted when `wr_start & start_ready`. `wr_start` without `start_ready` is ignored; it is not queued.
- Transitions:
  - IDLE/POST, burst accepted: go to PRE.
  - PRE: go to DATA.
  - DATA, `wcnt < N-1`: stay in DATA.
  - DATA, last word, burst accepted: stay in DATA with the new N and `wcnt = 0`. This is seamless; there is no POST/PRE between the bursts.
  - DATA, last word, no burst accepted: go to POST.
  - POST, no burst accepted: go to IDLE.
- Data loading: at every posedge that enters or continues a DATA cycle, the FIFO head (first-word-fall-through) is popped into `lo_q`/`hi_q` and the matching mask into `mlo_q`/`mhi_q`. `hi_q` is re-registered at negedge into `hi_n`.
- DDR mux: `dq = clock ? lo_q : hi_n`, and `dm` follows the same selection from the mask registers.
- Underrun is impossible by construction because `start_ready` guarantees N words are present.
- Outputs by state:
  - `dq_oe` is high in DATA only.
  - `dqs_oe` is high in PRE, DATA and POST.
  - `dqs`: 0 in PRE and POST; equals `clock` in DATA.
- Reset values:
  - FSM in IDLE; FIFO empty.
  - `in_ready`=1, `start_ready`=0, `busy`=0.
  - `dq`=0, `dm`=0, `dq_oe`=0, `dqs`=0, `dqs_oe`=0.
  - `lo_q`, `hi_q` and `hi_n` cleared.
- Reset during a burst aborts it, flushes the FIFO, and drives the reset values from the next posedge.

## Timing
- Burst accepted at posedge T:
  - Cycle T..T+1 is PRE.
  - DATA occupies cycles T+1 .. T+N.
  - POST is cycle T+N+1, unless a seamless burst follows.
- Beat order per DATA cycle: `lo` while `clock` is high, `hi` while `clock` is low. BL8 gives 8 beats, BC4 gives 4.
- Input to DQ latency, empty FIFO, start issued as soon as legal: a word pushed at edge P becomes visible in FIFO count at P. `wr_start` is then accepted no earlier than the edge at which count reaches N.
- `in_ready` and `start_ready` are combinational from registered state and count. `start_ready` also depends on the combinational pop condition.

## Configuration
- Macro: `DDR_WR_DM_EN`.
- Defined: masks are stored in the FIFO (width 2*BW + 2*BW/8) and `dm` is driven as described.
- Undefined: the FIFO holds data only, `in_mask` is ignored, and `dm` is constant 0.
- The port list is identical in both cases.

## Structure
- Package `ddr_wr_pkg` holds:
  - state enum `wr_state_e` (IDLE, PRE, DATA, POST);
  - constants `BL8_WORDS=4` and `BC4_WORDS=2`;
  - function `words_for(bc4)`.
- Sub-module `wr_data_fifo`:
  - synchronous FIFO with show-ahead output;
  - parameters WIDTH and DEPTH;
  - ports push, pop, full, empty, count, din, dout.
  - Simultaneous push and pop when not full or empty keeps count unchanged.

## Test plan
- Reset mid-BL8 burst, at the second DATA cycle: next posedge all outputs at reset values, `busy`=0, `in_ready`=1, FIFO count 0.
- Push words 0x1100, 0x3322, 0x5544, 0x7766, then `wr_start` with `bc4`=0 (BW=8): PRE for 1 cycle with `dqs_oe`=1, `dqs`=0. The following beats are 00,11,22,33,44,55,66,77. POST for 1 cycle, then IDLE.
- Push 2 words, assert `wr_start` with `bc4`=0: `start_ready`=0 and the burst is ignored. With `bc4`=1 the burst is accepted and produces 4 beats.
- Push 8 words, issue a BL8 then a second `wr_start` at the last DATA cycle: 16 contiguous beats with `dqs_oe` continuously high, no PRE/POST gap, and a single POST at the end.
- Fill FIFO to DEPTH with `in_valid` held: `in_ready`=0 and the extra word is not stored. After one burst pops 4 words, `in_ready`=1.
- `DDR_WR_DM_EN` defined, `in_mask`=2'b10 on the first word: `dm`=0 on beat 0 and 1 on beat 1. With the macro undefined, `dm`=0 on all beats.
